// File: rtl/bus_rr_xbar.sv
// bus_rr_xbar: N-host x M-device bus interconnect with one transaction in flight.
// Hosts are picked round-robin and granted in the same cycle as their request.
// The address goes to the lowest-indexed device whose base/mask window matches.
// An access that matches no device is answered with an error one cycle later.
// Optional feature macro: BUS_TIMEOUT_EN. When it is defined, a device that does
// not answer within TimeoutCycles WAIT cycles gets an error response instead.
module bus_rr_xbar #(
  parameter int NrHosts       = 2,
  parameter int NrDevices     = 4,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NrHosts-1:0]      host_req_i,
  input  logic [NrHosts-1:0]      host_we_i,
  input  logic [AddressWidth-1:0] host_addr_i          [NrHosts],
  input  logic [DataWidth/8-1:0]  host_be_i            [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i         [NrHosts],
  output logic [NrHosts-1:0]      host_gnt_o,
  output logic [NrHosts-1:0]      host_rvalid_o,
  output logic [NrHosts-1:0]      host_err_o,
  output logic [DataWidth-1:0]    host_rdata_o         [NrHosts],
  output logic [NrDevices-1:0]    device_req_o,
  output logic [NrDevices-1:0]    device_we_o,
  output logic [AddressWidth-1:0] device_addr_o        [NrDevices],
  output logic [DataWidth/8-1:0]  device_be_o          [NrDevices],
  output logic [DataWidth-1:0]    device_wdata_o       [NrDevices],
  input  logic [NrDevices-1:0]    device_rvalid_i,
  input  logic [NrDevices-1:0]    device_err_i,
  input  logic [DataWidth-1:0]    device_rdata_i       [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

  localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  // These parameter values would produce a bus that does not work, so elaboration stops.
  if (NrHosts < 1 || NrDevices < 1 || TimeoutCycles < 2) begin : g_param_check
    $error("bus_rr_xbar: NrHosts/NrDevices must be >= 1 and TimeoutCycles >= 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StErrRsp
  } state_e;

  state_e              state_q, state_d;
  logic [HostIdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [HostIdxW-1:0] cur_host_q, cur_host_d;
  logic [DevIdxW-1:0]  cur_dev_q, cur_dev_d;

  logic                arb_valid;
  logic [HostIdxW-1:0] arb_host;
  logic [HostIdxW-1:0] arb_cand;
  logic                dec_valid;
  logic [DevIdxW-1:0]  dec_dev;

`ifdef BUS_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            expired;

  // Cycle TimeoutCycles of WAIT is the last one the device gets.
  assign expired = (cnt_q == CntW'(TimeoutCycles - 1));
`endif

  // Round-robin search: the first requesting host at or after rr_ptr wins.
  always_comb begin
    arb_valid = 1'b0;
    arb_host  = '0;
    arb_cand  = '0;
    for (int i = 0; i < NrHosts; i++) begin
      arb_cand = HostIdxW'((int'(rr_ptr_q) + i) % NrHosts);
      if (!arb_valid && host_req_i[arb_cand]) begin
        arb_valid = 1'b1;
        arb_host  = arb_cand;
      end
    end
  end

  // Address decode of the winning host: the lowest matching device index wins.
  always_comb begin
    dec_valid = 1'b0;
    dec_dev   = '0;
    for (int d = 0; d < NrDevices; d++) begin
      if (!dec_valid &&
          ((host_addr_i[arb_host] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d])) begin
        dec_valid = 1'b1;
        dec_dev   = DevIdxW'(d);
      end
    end
  end

  // Next-state logic and all bus outputs. Every output is forced low while reset is held.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_host_d = cur_host_q;
    cur_dev_d  = cur_dev_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    for (int h = 0; h < NrHosts; h++) host_rdata_o[h] = '0;
    device_req_o = '0;
    device_we_o  = '0;
    for (int d = 0; d < NrDevices; d++) begin
      device_addr_o[d]  = '0;
      device_be_o[d]    = '0;
      device_wdata_o[d] = '0;
    end

    if (!rst_i) begin
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            host_gnt_o[arb_host] = 1'b1;
            rr_ptr_d   = (arb_host == HostIdxW'(NrHosts - 1)) ? '0 : arb_host + HostIdxW'(1);
            cur_host_d = arb_host;
            if (dec_valid) begin
              device_req_o[dec_dev]   = 1'b1;
              device_we_o[dec_dev]    = host_we_i[arb_host];
              device_addr_o[dec_dev]  = host_addr_i[arb_host];
              device_be_o[dec_dev]    = host_be_i[arb_host];
              device_wdata_o[dec_dev] = host_wdata_i[arb_host];
              cur_dev_d = dec_dev;
              state_d   = StWait;
`ifdef BUS_TIMEOUT_EN
              cnt_d     = '0;
`endif
            end else begin
              state_d = StErrRsp;
            end
          end
        end
        StWait: begin
          if (device_rvalid_i[cur_dev_q]) begin
            host_rvalid_o[cur_host_q] = 1'b1;
            host_err_o[cur_host_q]    = device_err_i[cur_dev_q];
            host_rdata_o[cur_host_q]  = device_rdata_i[cur_dev_q];
            state_d = StIdle;
          end
`ifdef BUS_TIMEOUT_EN
          else if (expired) begin
            host_rvalid_o[cur_host_q] = 1'b1;
            host_err_o[cur_host_q]    = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
`endif
        end
        StErrRsp: begin
          host_rvalid_o[cur_host_q] = 1'b1;
          host_err_o[cur_host_q]    = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM state, round-robin pointer and the owner of the in-flight transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      cur_host_q <= '0;
      cur_dev_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_host_q <= cur_host_d;
      cur_dev_q  <= cur_dev_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Counts WAIT cycles so that a silent device cannot lock up the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_bus_rr_xbar.sv
// Testbench for bus_rr_xbar: two hosts and the four-device system map.
// Expected responses are queued as each request is driven and popped on the response cycle.
// With BUS_TIMEOUT_EN defined, the silent-device case expects a timeout error response.
module tb_bus_rr_xbar;

  logic        clk_i;
  logic        rst_i;
  logic [1:0]  host_req_i;
  logic [1:0]  host_we_i;
  logic [31:0] host_addr_i  [2];
  logic [3:0]  host_be_i    [2];
  logic [31:0] host_wdata_i [2];
  logic [1:0]  host_gnt_o;
  logic [1:0]  host_rvalid_o;
  logic [1:0]  host_err_o;
  logic [31:0] host_rdata_o [2];
  logic [3:0]  device_req_o;
  logic [3:0]  device_we_o;
  logic [31:0] device_addr_o  [4];
  logic [3:0]  device_be_o    [4];
  logic [31:0] device_wdata_o [4];
  logic [3:0]  device_rvalid_i;
  logic [3:0]  device_err_i;
  logic [31:0] device_rdata_i [4];
  logic [31:0] cfg_device_addr_base [4];
  logic [31:0] cfg_device_addr_mask [4];

  typedef struct {
    logic [0:0]  host;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

`ifdef BUS_TIMEOUT_EN
  localparam int StallCycles = 3;
`else
  localparam int StallCycles = 5;
`endif

  bus_rr_xbar #(
    .NrHosts(2), .NrDevices(4), .DataWidth(32), .AddressWidth(32), .TimeoutCycles(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_err_o(host_err_o),
    .host_rdata_o(host_rdata_o),
    .device_req_o(device_req_o), .device_we_o(device_we_o), .device_addr_o(device_addr_o),
    .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_err_i(device_err_i),
    .device_rdata_i(device_rdata_i),
    .cfg_device_addr_base(cfg_device_addr_base), .cfg_device_addr_mask(cfg_device_addr_mask)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives inputs just after the falling edge, then waits 1 unit so outputs settle before sampling.
  task automatic applyStimulus(input logic [1:0] req, input logic [3:0] dvalid);
    @(negedge clk_i);
    host_req_i      = req;
    device_rvalid_i = dvalid;
    #1;
  endtask

  task automatic pushExpected(input logic [0:0] h, input logic err, input logic [31:0] rdata);
    rsp_t e;
    e.host  = h;
    e.err   = err;
    e.rdata = rdata;
    sbQ.push_back(e);
  endtask

  task automatic popResponse(input string tag);
    rsp_t e;
    checkOutput({tag, "_avail"}, 32'(sbQ.size() != 0), 32'd1);
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checkOutput({tag, "_rvalid"}, 32'(host_rvalid_o), 32'(2'b01 << e.host));
      checkOutput({tag, "_err"}, 32'(host_err_o[e.host]), 32'(e.err));
      checkOutput({tag, "_rdata"}, host_rdata_o[e.host], e.rdata);
      checkOutput({tag, "_other_rdata"}, host_rdata_o[~e.host], 32'd0);
    end
  endtask

  task automatic resetDut();
    @(negedge clk_i);
    rst_i           = 1'b1;
    host_req_i      = '0;
    device_rvalid_i = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Directed sequence covering each bus scenario in turn.
  initial begin
    logic [0:0] h;
    logic [1:0] dev;
    rst_i           = 1'b1;
    host_req_i      = '0;
    host_we_i       = '0;
    host_addr_i     = '{default: '0};
    host_be_i       = '{default: 4'hF};
    host_wdata_i    = '{default: '0};
    device_rvalid_i = '0;
    device_err_i    = '0;
    device_rdata_i  = '{default: '0};
    cfg_device_addr_base = '{32'h0010_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
    cfg_device_addr_mask = '{32'hFFF0_0000, 32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFFF_FC00};
    $display("[TB] start");

    // Reset: requests must not be granted and every output stays low.
    applyStimulus(2'b11, 4'b0000);
    checkOutput("rst_gnt", 32'(host_gnt_o), 32'd0);
    checkOutput("rst_rvalid", 32'(host_rvalid_o), 32'd0);
    checkOutput("rst_err", 32'(host_err_o), 32'd0);
    checkOutput("rst_dreq", 32'(device_req_o), 32'd0);
    checkOutput("rst_daddr0", device_addr_o[0], 32'd0);
    checkOutput("rst_rdata0", host_rdata_o[0], 32'd0);
    host_req_i = '0;
    @(negedge clk_i);
    rst_i = 1'b0;

    // Host0 reads RAM; RAM answers one cycle later.
    host_addr_i[0] = 32'h0010_0010;
    applyStimulus(2'b01, 4'b0000);
    checkOutput("ram_gnt", 32'(host_gnt_o), 32'd1);
    checkOutput("ram_dreq", 32'(device_req_o), 32'b0001);
    checkOutput("ram_daddr", device_addr_o[0], 32'h0010_0010);
    checkOutput("ram_no_early_rvalid", 32'(host_rvalid_o), 32'd0);
    pushExpected(1'b0, 1'b0, 32'hDEAD_BEEF);
    device_rdata_i[0] = 32'hDEAD_BEEF;
    applyStimulus(2'b00, 4'b0001);
    checkOutput("ram_wait_gnt", 32'(host_gnt_o), 32'd0);
    checkOutput("ram_dreq_once", 32'(device_req_o), 32'd0);
    popResponse("ram_rsp");
    applyStimulus(2'b00, 4'b0000);
    checkOutput("ram_rvalid_drop", 32'(host_rvalid_o), 32'd0);
    checkOutput("ram_rdata_zero", host_rdata_o[0], 32'd0);

    // Both hosts request continuously: grants alternate 0,1,0,1.
    resetDut();
    host_addr_i[0] = 32'h0010_0020;
    host_we_i      = 2'b10;
    host_addr_i[1] = 32'h0004_0004;
    host_wdata_i[1] = 32'h1111_2222;
    host_be_i[1]   = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      h   = 1'(k % 2);
      dev = (h == 1'b1) ? 2'd3 : 2'd0;
      applyStimulus(2'b11, 4'b0000);
      checkOutput($sformatf("rr%0d_gnt", k), 32'(host_gnt_o), 32'(2'b01 << h));
      checkOutput($sformatf("rr%0d_dreq", k), 32'(device_req_o), 32'(4'b0001 << dev));
      if (h == 1'b1) begin
        checkOutput($sformatf("rr%0d_posit_addr", k), device_addr_o[3], 32'h0004_0004);
        checkOutput($sformatf("rr%0d_posit_wdata", k), device_wdata_o[3], 32'h1111_2222);
        checkOutput($sformatf("rr%0d_posit_we", k), 32'(device_we_o[3]), 32'd1);
        checkOutput($sformatf("rr%0d_posit_be", k), 32'(device_be_o[3]), 32'b0011);
      end
      pushExpected(h, 1'b0, 32'hA000 + 32'(k));
      device_rdata_i[dev] = 32'hA000 + 32'(k);
      applyStimulus(2'b11, 4'b0001 << dev);
      checkOutput($sformatf("rr%0d_wait_gnt", k), 32'(host_gnt_o), 32'd0);
      popResponse($sformatf("rr%0d_rsp", k));
    end

    // Host1 writes an unmapped address: error one cycle after the grant.
    host_addr_i[1] = 32'h0005_0000;
    applyStimulus(2'b10, 4'b0000);
    checkOutput("unmap_gnt", 32'(host_gnt_o), 32'b10);
    checkOutput("unmap_dreq", 32'(device_req_o), 32'd0);
    pushExpected(1'b1, 1'b1, 32'd0);
    applyStimulus(2'b00, 4'b0000);
    checkOutput("unmap_rsp_gnt", 32'(host_gnt_o), 32'd0);
    popResponse("unmap_rsp");

    // Timer stalls while other devices raise spurious rvalid; host1 waits its turn.
    host_we_i      = 2'b00;
    host_addr_i[0] = 32'h0003_0008;
    host_addr_i[1] = 32'h0002_0000;
    device_rdata_i = '{32'hBAD0, 32'hBAD1, 32'h0, 32'hBAD3};
    device_err_i   = 4'b1011;
    applyStimulus(2'b01, 4'b0000);
    checkOutput("timer_gnt", 32'(host_gnt_o), 32'd1);
    checkOutput("timer_dreq", 32'(device_req_o), 32'b0100);
    for (int s = 0; s < StallCycles; s++) begin
      applyStimulus(2'b10, 4'b1011);
      checkOutput($sformatf("stall%0d_gnt", s), 32'(host_gnt_o), 32'd0);
      checkOutput($sformatf("stall%0d_rvalid", s), 32'(host_rvalid_o), 32'd0);
    end
    pushExpected(1'b0, 1'b0, 32'h1234_5678);
    device_rdata_i[2] = 32'h1234_5678;
    applyStimulus(2'b10, 4'b0100);
    popResponse("timer_rsp");
    applyStimulus(2'b10, 4'b0000);
    checkOutput("simctrl_gnt", 32'(host_gnt_o), 32'b10);
    checkOutput("simctrl_dreq", 32'(device_req_o), 32'b0010);
    checkOutput("simctrl_addr", device_addr_o[1], 32'h0002_0000);
    pushExpected(1'b1, 1'b0, 32'h00C0_FFEE);
    device_rdata_i[1] = 32'h00C0_FFEE;
    device_err_i      = 4'b0000;
    applyStimulus(2'b00, 4'b0010);
    popResponse("simctrl_rsp");

    // Device that does not answer.
    host_addr_i[0]    = 32'h0002_0004;
    device_rdata_i[1] = 32'h55;
    applyStimulus(2'b01, 4'b0000);
    checkOutput("silent_gnt", 32'(host_gnt_o), 32'd1);
    checkOutput("silent_dreq", 32'(device_req_o), 32'b0010);
`ifdef BUS_TIMEOUT_EN
    for (int w = 1; w < 4; w++) begin
      applyStimulus(2'b00, 4'b0000);
      checkOutput($sformatf("to_wait%0d_rvalid", w), 32'(host_rvalid_o), 32'd0);
    end
    pushExpected(1'b0, 1'b1, 32'd0);
    applyStimulus(2'b00, 4'b0000);
    popResponse("timeout_rsp");
    applyStimulus(2'b00, 4'b0010);
    checkOutput("late_rvalid_ignored", 32'(host_rvalid_o), 32'd0);
`else
    for (int w = 1; w < 9; w++) begin
      applyStimulus(2'b00, 4'b0000);
      checkOutput($sformatf("hold_wait%0d_rvalid", w), 32'(host_rvalid_o), 32'd0);
    end
    pushExpected(1'b0, 1'b0, 32'h55);
    applyStimulus(2'b00, 4'b0010);
    popResponse("slow_rsp");
`endif
    applyStimulus(2'b00, 4'b0000);

    // Reset in WAIT: outputs drop at once and the pointer returns to host0.
    host_addr_i[0] = 32'h0010_0000;
    applyStimulus(2'b01, 4'b0000);
    checkOutput("pre_rst_gnt", 32'(host_gnt_o), 32'd1);
    @(negedge clk_i);
    rst_i             = 1'b1;
    host_req_i        = 2'b11;
    device_rvalid_i   = 4'b0001;
    device_rdata_i[0] = 32'h77;
    #1;
    checkOutput("midrst_gnt", 32'(host_gnt_o), 32'd0);
    checkOutput("midrst_rvalid", 32'(host_rvalid_o), 32'd0);
    checkOutput("midrst_dreq", 32'(device_req_o), 32'd0);
    checkOutput("midrst_rdata0", host_rdata_o[0], 32'd0);
    @(negedge clk_i);
    rst_i           = 1'b0;
    device_rvalid_i = 4'b0000;
    #1;
    checkOutput("postrst_gnt_host0", 32'(host_gnt_o), 32'b01);
    checkOutput("postrst_dreq", 32'(device_req_o), 32'b0001);
    pushExpected(1'b0, 1'b0, 32'h99);
    device_rdata_i[0] = 32'h99;
    applyStimulus(2'b00, 4'b0001);
    popResponse("postrst_rsp");
    applyStimulus(2'b00, 4'b0000);
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
